// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared types and helpers for the push-button conditioning path.
//   btn_state_t : per-button debounce FSM state
//   cnt_width() : width of the per-button stability counter
// -----------------------------------------------------------------------------
package btn_pkg;

  // Bit 1 of the encoding equals the debounced level.
  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    HELD         = 2'b10,
    RELEASE_WAIT = 2'b11
  } btn_state_t;

  // The counter only has to reach cycles-1, so $clog2(cycles) bits suffice.
  // It is clamped to one bit so a degenerate parameter still elaborates.
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
// One button lane: two-flop synchroniser, debounce FSM with stability counter,
// and registered press/release pulse generation.
// Ports:
//   clk       in  system clock
//   rst       in  synchronous active-high reset
//   btn_i     in  raw asynchronous button input (1 = pressed)
//   level_o   out debounced level
//   press_o   out one-cycle pulse on an accepted press
//   release_o out one-cycle pulse on an accepted release
// -----------------------------------------------------------------------------
module debounce_bit
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync_q;
  logic             s;
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  // Only the second synchroniser flop is safe to use in logic.
  assign s = sync_q[1];

  // The counter holds how many consecutive samples have disagreed with the
  // accepted level; it is cleared on every state change so it never wraps.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case statement leaves a variable unassigned (no latch).
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Level is derived from the next state so it moves in the same cycle as
    // the press/release pulse.
    level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values, whatever order the statements are written in.
    if (rst) begin
      sync_q    <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
// Conditions N_BTN raw push buttons into clean levels plus single-cycle press
// and release pulses. Lanes are fully independent; simultaneous transitions on
// several buttons pulse in the same cycle.
// Ports:
//   clk         in  system clock
//   rst         in  synchronous active-high reset
//   btn_in      in  [N_BTN] raw asynchronous button inputs (1 = pressed)
//   btn_level   out [N_BTN] debounced button state
//   btn_press   out [N_BTN] one-cycle pulse per accepted press
//   btn_release out [N_BTN] one-cycle pulse per accepted release
// -----------------------------------------------------------------------------
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk      (clk),
      .rst      (rst),
      .btn_i    (btn_in[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
// Directed vector table for the listed corner cases, followed by randomized
// button activity compared against a behavioural model: an input is accepted
// once DEBOUNCE_CYCLES consecutive synchronised samples differ from the
// current level.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

  localparam int N = 2;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_level, btn_press, btn_release;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  typedef struct {
    logic         r;
    logic [N-1:0] in;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [N-1:0] in, input logic [N-1:0] lvl,
                     input logic [N-1:0] prs, input logic [N-1:0] rel, input int n);
    for (int i = 0; i < n; i++) vecs.push_back('{r, in, lvl, prs, rel});
  endtask

  // Behavioural model: two-stage sample delay, then a run length of samples
  // disagreeing with the accepted level.
  logic [N-1:0] m_s1, m_s2, m_lvl, m_prs, m_rel;
  int           m_run[N];

  task automatic model_edge(input logic r, input logic [N-1:0] in);
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0;
      for (int b = 0; b < N; b++) m_run[b] = 0;
    end else begin
      for (int b = 0; b < N; b++) begin
        m_prs[b] = 1'b0;
        m_rel[b] = 1'b0;
        if (m_s2[b] != m_lvl[b]) begin
          m_run[b]++;
          if (m_run[b] == D) begin
            m_lvl[b] = m_s2[b];
            if (m_s2[b]) m_prs[b] = 1'b1;
            else         m_rel[b] = 1'b1;
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = in;
    end
  endtask

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, then sample outputs 1 ns later.
  task automatic cycle(input logic r, input logic [N-1:0] in);
    rst    = r;
    btn_in = in;
    @(posedge clk);
    model_edge(r, in);
    #1;
  endtask

  logic [N-1:0] cur;
  int           hold[N];
  logic         r_rand;

  initial begin
    rst    = 1'b1;
    btn_in = '0;
    for (int b = 0; b < N; b++) m_run[b] = 0;
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0;

    // Reset held with both buttons pressed: outputs stay low.
    add(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 10);
    // Clean press on bit 0: accepted on the 6th edge.
    add(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 5);
    add(1'b0, 2'b01, 2'b01, 2'b01, 2'b00, 1);
    add(1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2);
    add(1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 5);
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 1);
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2);
    // Bounce 1,1,0,1,1,0 then 0: never accepted.
    add(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2);
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
    add(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2);
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 8);
    // Simultaneous press and release of both buttons.
    add(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 5);
    add(1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 1);
    add(1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 3);
    add(1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 5);
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 1);
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2);
    // Hold 20 cycles: exactly one press, release 6 edges after the fall.
    add(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 5);
    add(1'b0, 2'b01, 2'b01, 2'b01, 2'b00, 1);
    add(1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 14);
    add(1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 5);
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 1);
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2);
    // Reset on edge 4 of a press: count discarded, press 6 edges after reset.
    add(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 3);
    add(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1);
    add(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 5);
    add(1'b0, 2'b01, 2'b01, 2'b01, 2'b00, 1);
    add(1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2);
    add(1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 5);
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 1);
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2);

    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].in);
      check($sformatf("vec%0d level", i),   btn_level,   vecs[i].lvl);
      check($sformatf("vec%0d press", i),   btn_press,   vecs[i].prs);
      check($sformatf("vec%0d release", i), btn_release, vecs[i].rel);
    end

    // Randomized activity: mixes short bounces with holds long enough to be
    // accepted, plus rare resets.
    cycle(1'b1, '0);
    cycle(1'b1, '0);
    cur = '0;
    for (int b = 0; b < N; b++) hold[b] = 0;
    for (int t = 0; t < 800; t++) begin
      for (int b = 0; b < N; b++) begin
        if (hold[b] == 0) begin
          cur[b]  = 1'($urandom_range(0, 1));
          hold[b] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4)
                                                : $urandom_range(4, 14);
        end
        hold[b]--;
      end
      r_rand = ($urandom_range(0, 149) == 0);
      cycle(r_rand, cur);
      check($sformatf("rand%0d level", t),   btn_level,   m_lvl);
      check($sformatf("rand%0d press", t),   btn_press,   m_prs);
      check($sformatf("rand%0d release", t), btn_release, m_rel);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
